// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin share of the reg_file write port among ALU/LSU/MUL, plus RAW scoreboard.
// Grant to w_en is 1 cycle and the arbiter never stalls; WB_BYPASS_EN clears busy at grant and exposes forwarding.
`ifndef WORDSZ
`define WORDSZ 32
`endif
`ifndef REGADDRSZ
`define REGADDRSZ 5
`endif
`ifndef NREGS
`define NREGS 32
`endif

module wb_arbiter #(
  parameter int WORDSZ    = `WORDSZ,
  parameter int REGADDRSZ = `REGADDRSZ,
  parameter int NREGS     = `NREGS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             req_valid,
  input  logic [3*REGADDRSZ-1:0] req_rd,
  input  logic [3*WORDSZ-1:0]    req_val,
  output logic [2:0]             req_ready,
  output logic                   w_en,
  output logic [REGADDRSZ-1:0]   rd_addr,
  output logic [WORDSZ-1:0]      rd_val,
  input  logic                   iss_valid,
  input  logic [REGADDRSZ-1:0]   iss_rd,
  input  logic [REGADDRSZ-1:0]   rs1_addr,
  input  logic [REGADDRSZ-1:0]   rs2_addr,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [NREGS-1:0]       busy_vec,
  output logic                   rs1_fwd,
  output logic                   rs2_fwd,
  output logic [WORDSZ-1:0]      rs1_fwd_val,
  output logic [WORDSZ-1:0]      rs2_fwd_val
);

  logic [1:0]           r_ptr;
  logic [NREGS-1:0]     r_busy;

  logic [1:0]           w_p1;
  logic [1:0]           w_p2;
  logic                 w_gnt_any;
  logic [1:0]           w_gnt_idx;
  logic [1:0]           w_ptr_nxt;
  logic [REGADDRSZ-1:0] w_gnt_rd;
  logic [WORDSZ-1:0]    w_gnt_val;
  logic [NREGS-1:0]     w_set_mask;
  logic [NREGS-1:0]     w_clr_mask;
  logic [NREGS-1:0]     w_busy_nxt;

  assign w_p1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
  assign w_p2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;

  always_comb begin
    w_gnt_any = 1'b1;
    w_gnt_idx = r_ptr;
    if (req_valid[r_ptr])      w_gnt_idx = r_ptr;
    else if (req_valid[w_p1])  w_gnt_idx = w_p1;
    else if (req_valid[w_p2])  w_gnt_idx = w_p2;
    else                       w_gnt_any = 1'b0;
  end

  assign w_ptr_nxt = (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;

  // A requester must not see a grant while reset is held, or its write would be lost.
  assign req_ready = (w_gnt_any && reset) ? (3'b001 << w_gnt_idx) : 3'b000;

  always_comb begin
    w_gnt_rd  = req_rd[REGADDRSZ-1:0];
    w_gnt_val = req_val[WORDSZ-1:0];
    case (w_gnt_idx)
      2'd1: begin
        w_gnt_rd  = req_rd[2*REGADDRSZ-1:REGADDRSZ];
        w_gnt_val = req_val[2*WORDSZ-1:WORDSZ];
      end
      2'd2: begin
        w_gnt_rd  = req_rd[3*REGADDRSZ-1:2*REGADDRSZ];
        w_gnt_val = req_val[3*WORDSZ-1:2*WORDSZ];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= 2'd0;
      w_en    <= 1'b0;
      rd_addr <= '0;
      rd_val  <= '0;
    end else begin
      w_en <= w_gnt_any && (w_gnt_rd != '0);
      if (w_gnt_any) begin
        r_ptr   <= w_ptr_nxt;
        rd_addr <= w_gnt_rd;
        rd_val  <= w_gnt_val;
      end
    end
  end

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
`ifdef WB_BYPASS_EN
    if (w_gnt_any) w_clr_mask[w_gnt_rd] = 1'b1;
`else
    if (w_en) w_clr_mask[rd_addr] = 1'b1;
`endif
    if (iss_valid && (iss_rd != '0)) w_set_mask[iss_rd] = 1'b1;
    // Set is applied after clear: the clear belongs to an older instruction.
    w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;
  assign rs1_busy = r_busy[rs1_addr];
  assign rs2_busy = r_busy[rs2_addr];

`ifdef WB_BYPASS_EN
  assign rs1_fwd     = w_en && (rd_addr == rs1_addr) && (rs1_addr != '0);
  assign rs2_fwd     = w_en && (rd_addr == rs2_addr) && (rs2_addr != '0);
  assign rs1_fwd_val = rd_val;
  assign rs2_fwd_val = rd_val;
`else
  assign rs1_fwd     = 1'b0;
  assign rs2_fwd     = 1'b0;
  assign rs1_fwd_val = '0;
  assign rs2_fwd_val = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reference model plus write scoreboard queue, immediate-assertion checks.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_val;
  logic [2:0]  req_ready;
  logic        w_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic [31:0] busy_vec;
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_val, rs2_fwd_val;

  logic [4:0]  rq_rd [3];
  logic [31:0] rq_val[3];
  assign req_rd  = {rq_rd[2], rq_rd[1], rq_rd[0]};
  assign req_val = {rq_val[2], rq_val[1], rq_val[0]};

  wb_arbiter #(.WORDSZ(32), .REGADDRSZ(5), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd), .req_val(req_val),
    .req_ready(req_ready), .w_en(w_en), .rd_addr(rd_addr), .rd_val(rd_val),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_vec(busy_vec),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .rs1_fwd_val(rs1_fwd_val), .rs2_fwd_val(rs2_fwd_val)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] val; } wr_t;
  wr_t q[$];

  int          checks = 0;
  int          errors = 0;
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  logic [31:0] m_busy;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_idx(int p, logic [2:0] v);
    for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wen = 1'b0; m_rd = '0; m_val = '0; m_busy = '0;
    q.delete();
  endtask

  // One clock: inputs are already driven; checks before and after the edge.
  task automatic cyc();
    int          g;
    logic [2:0]  er;
    logic [31:0] nb;
    wr_t         e;
    #1;
    g  = exp_idx(m_ptr, req_valid);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
    chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
`ifdef WB_BYPASS_EN
    chk("rs1_fwd", rs1_fwd, m_wen && (m_rd == rs1_addr) && (rs1_addr != 0));
    chk("rs2_fwd", rs2_fwd, m_wen && (m_rd == rs2_addr) && (rs2_addr != 0));
`else
    chk("rs1_fwd", rs1_fwd, 0);
    chk("rs2_fwd_val", rs2_fwd_val, 0);
`endif
    nb = m_busy;
`ifdef WB_BYPASS_EN
    if (g >= 0) nb[rq_rd[g]] = 1'b0;
`else
    if (m_wen) nb[m_rd] = 1'b0;
`endif
    if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
    nb[0] = 1'b0;
    if (g >= 0) begin
      if (rq_rd[g] != 0) q.push_back('{rd: rq_rd[g], val: rq_val[g]});
      m_wen = (rq_rd[g] != 0);
      m_rd  = rq_rd[g];
      m_val = rq_val[g];
      m_ptr = (g + 1) % 3;
    end else begin
      m_wen = 1'b0;
    end
    m_busy = nb;
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    chk("w_en", w_en, m_wen);
    if (w_en === 1'b1) begin
      if (q.size() == 0) chk("unexpected_write", w_en, 0);
      else begin
        e = q.pop_front();
        chk("wr_rd_addr", rd_addr, e.rd);
        chk("wr_rd_val", rd_val, e.val);
      end
    end else begin
      chk("hold_rd_addr", rd_addr, m_rd);
      chk("hold_rd_val", rd_val, m_val);
    end
    chk("busy_vec", busy_vec, m_busy);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 3; i++) begin rq_rd[i] = '0; rq_val[i] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_en", w_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_val", rd_val, 0);
    chk("rst_busy_vec", busy_vec, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rs1_fwd", rs1_fwd, 0);
    chk("rst_rs2_fwd", rs2_fwd, 0);
    chk("rst_rs1_fwd_val", rs1_fwd_val, 0);
    chk("rst_rs2_fwd_val", rs2_fwd_val, 0);
    reset = 1'b1;

    // Round robin with all three requesters continuously valid
    rq_rd[0] = 5'd1; rq_val[0] = 32'hA;
    rq_rd[1] = 5'd2; rq_val[1] = 32'hB;
    rq_rd[2] = 5'd3; rq_val[2] = 32'hC;
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", req_ready, 3'b001 << (k % 3));
      cyc();
      chk("rr_w_en", w_en, 1);
      chk("rr_rd_addr", rd_addr, (k % 3) + 1);
    end
    req_valid = '0;

    // Write to x0: grant completes, no write, no busy set
    rq_rd[1] = 5'd0; rq_val[1] = 32'hDEADBEEF; req_valid = 3'b010;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    chk("x0_ready", req_ready, 3'b010);
    cyc();
    req_valid = '0;
    chk("x0_w_en", w_en, 0);
    chk("x0_busy", busy_vec, 0);
    cyc();

    // Scoreboard lifecycle for rd=5
    iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5;
    cyc();
    chk("life_c1", busy_vec[5], 1);
    cyc();
    chk("life_c2", busy_vec[5], 1);
    cyc();
    chk("life_c3", busy_vec[5], 1);
    rq_rd[0] = 5'd5; rq_val[0] = 32'h55; req_valid = 3'b001;
    cyc();
    req_valid = '0;
`ifdef WB_BYPASS_EN
    chk("life_c4", busy_vec[5], 0);
`else
    chk("life_c4", busy_vec[5], 1);
`endif
    cyc();
    chk("life_c5", busy_vec[5], 0);

    // Set/clear collision on rd=7
    iss_valid = 1'b1; iss_rd = 5'd7;
    cyc();
    rq_rd[0] = 5'd7; rq_val[0] = 32'h77; req_valid = 3'b001;
    iss_valid = 1'b1; iss_rd = 5'd7;
    cyc();
    req_valid = '0;
    chk("coll_b", busy_vec[7], 1);
    iss_valid = 1'b1; iss_rd = 5'd7;
    cyc();
    chk("coll_c", busy_vec[7], 1);
    rq_val[0] = 32'h78; req_valid = 3'b001;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    chk("coll_drain", busy_vec[7], 0);

    // Forwarding window for rd=9
    iss_valid = 1'b1; iss_rd = 5'd9;
    cyc();
    rq_rd[1] = 5'd9; rq_val[1] = 32'h1234; req_valid = 3'b010;
    cyc();
    req_valid = '0; rs2_addr = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_rs2_fwd", rs2_fwd, 1);
    chk("byp_rs2_fwd_val", rs2_fwd_val, 32'h1234);
    chk("byp_rs2_busy", rs2_busy, 0);
`else
    chk("byp_rs2_fwd", rs2_fwd, 0);
    chk("byp_rs2_busy", rs2_busy, 1);
`endif
    cyc();
    cyc();

    // Reset asserted with a registered write pending
    rq_rd[2] = 5'd4; rq_val[2] = 32'h44; req_valid = 3'b100;
    iss_valid = 1'b1; iss_rd = 5'd6;
    cyc();
    chk("pre_rst_w_en", w_en, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_w_en", w_en, 0);
    chk("mid_rst_busy", busy_vec, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    model_reset();
    rq_rd[0] = 5'd1; rq_rd[1] = 5'd2; rq_rd[2] = 5'd3;
    req_valid = 3'b111;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("post_rst_grant", req_ready, 3'b001);
    cyc();
    cyc();
    req_valid = '0;
    cyc();
    chk("wr_queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
